// File: rtl/bx_paged_stub_buffer.sv
// Per-BX paged stub buffer: stubs fill a ring of RAM pages, each start closes the
// current page and publishes its (saturated) count; reads target a page READ_LAG behind.
module bx_paged_stub_buffer #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_BITS  = 6,
    parameter int PAGE_BITS  = 3,
    parameter int READ_LAG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_BITS-1:0]  read_add,
    output logic                  done,
    output logic [ADDR_BITS:0]    number_out,
    output logic                  overflow,
    output logic [PAGE_BITS-1:0]  wr_page,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int                  DEPTH    = 1 << (PAGE_BITS + ADDR_BITS);
    localparam logic [ADDR_BITS:0]  CNT_FULL = (ADDR_BITS + 1)'(1 << ADDR_BITS);
    localparam logic [PAGE_BITS-1:0] LAG     = PAGE_BITS'(READ_LAG);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PAGE_BITS-1:0]  wr_page_q, wr_page_d;
    logic [ADDR_BITS:0]    wr_cnt_q, wr_cnt_d;
    logic                  ovf_q, ovf_d;
    logic [ADDR_BITS:0]    number_q, number_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] ram_q, pipe_q, data_q;

    logic [PAGE_BITS-1:0]           ep_s;
    logic [ADDR_BITS:0]             ec_s;
    logic                           wr_en_s;
    logic [PAGE_BITS+ADDR_BITS-1:0] wr_addr_s;
    logic [PAGE_BITS+ADDR_BITS-1:0] rd_addr_s;

    // Next-state: a stub arriving with start lands at entry 0 of the new page.
    always_comb begin
        ep_s       = wr_page_q;
        ec_s       = wr_cnt_q;
        number_d   = number_q;
        overflow_d = overflow_q;
        if (start) begin
            ep_s       = wr_page_q + PAGE_BITS'(1);
            ec_s       = '0;
            number_d   = wr_cnt_q;
            overflow_d = ovf_q;
        end else begin
            ep_s = wr_page_q;
            ec_s = wr_cnt_q;
        end
        wr_en_s   = enable && (ec_s != CNT_FULL);
        wr_addr_s = {ep_s, ec_s[ADDR_BITS-1:0]};
        wr_page_d = ep_s;
        if (wr_en_s) begin
            wr_cnt_d = ec_s + (ADDR_BITS + 1)'(1);
        end else begin
            wr_cnt_d = ec_s;
        end
        if (start) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (enable & ~wr_en_s);
        end
        rd_addr_s = {wr_page_q - LAG, read_add};
    end

    // Control and published-status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_page_q  <= '1;
            wr_cnt_q   <= '0;
            ovf_q      <= 1'b0;
            number_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_page_q  <= wr_page_d;
            wr_cnt_q   <= wr_cnt_d;
            ovf_q      <= ovf_d;
            number_q   <= number_d;
            overflow_q <= overflow_d;
            done_q     <= start;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_q[wr_addr_s] <= data_in;
        end
    end

    // Read path: RAM read register, RAM output register, then output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_q  <= '0;
            pipe_q <= '0;
            data_q <= '0;
        end else begin
            ram_q  <= mem_q[rd_addr_s];
            pipe_q <= ram_q;
            data_q <= pipe_q;
        end
    end

    assign done       = done_q;
    assign number_out = number_q;
    assign overflow   = overflow_q;
    assign wr_page    = wr_page_q;
    assign data_out   = data_q;

endmodule
